spi_cmd_sequencer: RTL

Frame-level controller that sits above the byte-level SPI driver and sequences a complete SPI command frame (opcode, address, write payload, read payload) as a series of single-byte driver transfers. It accepts one command descriptor, pulls write bytes from a stream, pushes dummy `0x00` bytes during reads, and forwards the captured read bytes to a read stream. It guarantees one byte outstanding at the driver at a time, and aborts with an error pulse if the driver stops answering.

---
 rtl/spi_cmd_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - SPI command frame sequencer above a byte-level driver
// Issues opcode/address/write/read bytes one at a time; a silent driver aborts the frame.
module spi_cmd_sequencer #(
  parameter int P_ADDR_BYTES = 3,
  parameter int P_LEN_WIDTH  = 8,
  parameter int P_TIMEOUT    = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic [7:0]                i_cmd_opcode,
  input  logic [P_ADDR_BYTES*8-1:0] i_cmd_addr,
  input  logic                      i_cmd_addr_en,
  input  logic [P_LEN_WIDTH-1:0]    i_cmd_wr_len,
  input  logic [P_LEN_WIDTH-1:0]    i_cmd_rd_len,
  input  logic [7:0]                i_wr_data,
  input  logic                      i_wr_valid,
  output logic                      o_wr_ready,
  output logic [7:0]                o_rd_data,
  output logic                      o_rd_valid,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err,
  output logic [7:0]                o_drv_data,
  output logic                      o_drv_valid,
  input  logic                      i_drv_ready,
  input  logic [7:0]                i_drv_read_data,
  input  logic                      i_drv_read_valid
);

  localparam int AW = P_ADDR_BYTES * 8;
  localparam int CW = (P_ADDR_BYTES > 1) ? $clog2(P_ADDR_BYTES) : 1;
  localparam int TW = $clog2(P_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_OPCODE, S_ADDR, S_WRITE, S_READ, S_DONE, S_ERR
  } state_t;

  state_t                 state_q;
  state_t                 next_phase_d;
  state_t                 post_addr_d;
  logic [AW-1:0]          addr_q;
  logic                   addr_en_q;
  logic [P_LEN_WIDTH-1:0] wr_cnt_q;
  logic [P_LEN_WIDTH-1:0] rd_cnt_q;
  logic [CW-1:0]          addr_cnt_q;
  logic                   pending_q;
  logic [TW-1:0]          tmo_q;

  // A staged write byte is the driver byte itself, so "staged" is o_drv_valid.
  assign o_wr_ready = (state_q == S_WRITE) && !pending_q && !o_drv_valid;

  always_comb begin
    post_addr_d = S_DONE;
    if (wr_cnt_q != '0) begin
      post_addr_d = S_WRITE;
    end else if (rd_cnt_q != '0) begin
      post_addr_d = S_READ;
    end
    next_phase_d = state_q;
    case (state_q)
      S_OPCODE: next_phase_d = addr_en_q ? S_ADDR : post_addr_d;
      S_ADDR:   if (addr_cnt_q == CW'(P_ADDR_BYTES - 1)) next_phase_d = post_addr_d;
      S_WRITE:  if (wr_cnt_q == P_LEN_WIDTH'(1)) next_phase_d = (rd_cnt_q != '0) ? S_READ : S_DONE;
      S_READ:   if (rd_cnt_q == P_LEN_WIDTH'(1)) next_phase_d = S_DONE;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      addr_en_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      addr_cnt_q  <= '0;
      pending_q   <= 1'b0;
      tmo_q       <= '0;
      o_cmd_ready <= 1'b0;
      o_rd_data   <= 8'h00;
      o_rd_valid  <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_drv_data  <= 8'h00;
      o_drv_valid <= 1'b0;
    end else begin
      o_rd_valid <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          o_cmd_ready <= 1'b1;
          pending_q   <= 1'b0;
          if (i_cmd_valid && o_cmd_ready) begin
            o_cmd_ready <= 1'b0;
            o_busy      <= 1'b1;
            addr_q      <= i_cmd_addr;
            addr_en_q   <= i_cmd_addr_en;
            wr_cnt_q    <= i_cmd_wr_len;
            rd_cnt_q    <= i_cmd_rd_len;
            addr_cnt_q  <= '0;
            tmo_q       <= '0;
            o_drv_data  <= i_cmd_opcode;
            o_drv_valid <= 1'b1;
            state_q     <= S_OPCODE;
          end
        end
        S_DONE, S_ERR: begin
          o_busy      <= 1'b0;
          o_cmd_ready <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          // o_drv_valid is low while pending, so handshake and strobe never overlap here.
          if (o_drv_valid && i_drv_ready) begin
            o_drv_valid <= 1'b0;
            pending_q   <= 1'b1;
            tmo_q       <= '0;
          end else if (pending_q && i_drv_read_valid) begin
            pending_q <= 1'b0;
            tmo_q     <= '0;
            state_q   <= next_phase_d;
            case (state_q)
              S_ADDR:  addr_cnt_q <= addr_cnt_q + CW'(1);
              S_WRITE: wr_cnt_q <= wr_cnt_q - P_LEN_WIDTH'(1);
              S_READ: begin
                rd_cnt_q   <= rd_cnt_q - P_LEN_WIDTH'(1);
                o_rd_data  <= i_drv_read_data;
                o_rd_valid <= 1'b1;
              end
              default: ;
            endcase
            case (next_phase_d)
              S_ADDR: begin
                o_drv_data  <= addr_q[AW-1 -: 8];
                o_drv_valid <= 1'b1;
                addr_q      <= addr_q << 8;
              end
              S_READ: begin
                o_drv_data  <= 8'h00;
                o_drv_valid <= 1'b1;
              end
              S_DONE:  o_done <= 1'b1;
              default: ;
            endcase
          end else if (pending_q) begin
            if (tmo_q == TW'(P_TIMEOUT - 2)) begin
              pending_q   <= 1'b0;
              o_drv_valid <= 1'b0;
              o_err       <= 1'b1;
              state_q     <= S_ERR;
            end else begin
              tmo_q <= tmo_q + TW'(1);
            end
          end else if (o_wr_ready && i_wr_valid) begin
            o_drv_data  <= i_wr_data;
            o_drv_valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
